// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_pkg : shared widths, funct3 mem-opcode constants, LSU state encoding  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lsu_pkg;
    localparam int DATA_W   = 32;
    localparam int MEM_OP_W = 3;

    localparam logic [MEM_OP_W-1:0] LSU_LB  = 3'b000;
    localparam logic [MEM_OP_W-1:0] LSU_LH  = 3'b001;
    localparam logic [MEM_OP_W-1:0] LSU_LW  = 3'b010;
    localparam logic [MEM_OP_W-1:0] LSU_LBU = 3'b100;
    localparam logic [MEM_OP_W-1:0] LSU_LHU = 3'b101;
    localparam logic [MEM_OP_W-1:0] LSU_SB  = 3'b000;
    localparam logic [MEM_OP_W-1:0] LSU_SH  = 3'b001;
    localparam logic [MEM_OP_W-1:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DRAIN     = 2'd2
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_align : store lane replication/byteenable and load extract/extend     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          st_size_i,
    input  logic [1:0]          st_off_i,
    input  logic [DATA_W-1:0]   st_data_i,
    output logic [DATA_W-1:0]   st_data_o,
    output logic [3:0]          st_be_o,
    input  logic [MEM_OP_W-1:0] ld_op_i,
    input  logic [1:0]          ld_off_i,
    input  logic [DATA_W-1:0]   ld_data_i,
    output logic [DATA_W-1:0]   ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halfword lanes follow off[1] so an unaligned half still maps to a whole lane pair
    always_comb begin
        case (st_size_i)
            2'b00: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_be_o   = 4'b0001 << st_off_i;
            end
            2'b01: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data_o = st_data_i;
                st_be_o   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_data_i[7:0];
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            default: ld_byte = ld_data_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        case (ld_op_i[1:0])
            2'b00:   ld_data_o = {{24{ld_byte[7] & ~ld_op_i[2]}}, ld_byte};
            2'b01:   ld_data_o = {{16{ld_half[15] & ~ld_op_i[2]}}, ld_half};
            default: ld_data_o = ld_data_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu : MEM-stage load/store unit, pipelined data-bus master with stall.    |
// | Define LSU_MISALIGN_CHECK_EN to enable misalignment exceptions.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lsu
    import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_flush,
    input  logic                lsu_mem_read,
    input  logic                lsu_mem_write,
    input  logic [MEM_OP_W-1:0] lsu_mem_opcode,
    input  logic [DATA_W-1:0]   lsu_address,
    input  logic [DATA_W-1:0]   lsu_writedata,
    output logic [DATA_W-1:0]   lsu_readdata,
    output logic                lsu_stall,
    output logic                lsu_exc_load_misaligned,
    output logic                lsu_exc_store_misaligned,
    output logic                lsu_bus_read,
    output logic                lsu_bus_write,
    output logic [DATA_W-1:0]   lsu_bus_address,
    output logic [DATA_W-1:0]   lsu_bus_writedata,
    output logic [3:0]          lsu_bus_byteenable,
    input  logic                lsu_bus_waitrequest,
    input  logic [DATA_W-1:0]   lsu_bus_readdata,
    input  logic                lsu_bus_readdatavalid
);
    lsu_state_t          state_q, state_d;
    logic [MEM_OP_W-1:0] ld_op_q;
    logic [1:0]          ld_off_q;

    logic                misaligned;
    logic                req;
    logic                accept_load;
    logic [DATA_W-1:0]   st_data;
    logic [3:0]          st_be;
    logic [DATA_W-1:0]   ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(lsu_mem_opcode[1:0], lsu_address[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req         = (lsu_mem_read | lsu_mem_write) & ~misaligned & ~lsu_flush;
    assign accept_load = (state_q == IDLE) & req & lsu_mem_read & ~lsu_bus_waitrequest;

    lsu_align u_align (
        .st_size_i (lsu_mem_opcode[1:0]),
        .st_off_i  (lsu_address[1:0]),
        .st_data_i (lsu_writedata),
        .st_data_o (st_data),
        .st_be_o   (st_be),
        .ld_op_i   (ld_op_q),
        .ld_off_i  (ld_off_q),
        .ld_data_i (lsu_bus_readdata),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_op_q  <= '0;
            ld_off_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_load) begin
                ld_op_q  <= lsu_mem_opcode;
                ld_off_q <= lsu_address[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept_load) state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (lsu_bus_readdatavalid) state_d = IDLE;
                else if (lsu_flush)        state_d = DRAIN;
            end
            DRAIN:     if (lsu_bus_readdatavalid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu_readdata             = '0;
        lsu_stall                = 1'b0;
        lsu_exc_load_misaligned  = 1'b0;
        lsu_exc_store_misaligned = 1'b0;
        lsu_bus_read             = 1'b0;
        lsu_bus_write            = 1'b0;
        lsu_bus_address          = '0;
        lsu_bus_writedata        = '0;
        lsu_bus_byteenable       = 4'b0000;
        case (state_q)
            IDLE: begin
                lsu_bus_read             = req & lsu_mem_read;
                lsu_bus_write            = req & lsu_mem_write;
                lsu_bus_address          = req ? {lsu_address[DATA_W-1:2], 2'b00} : '0;
                lsu_bus_writedata        = (req & lsu_mem_write) ? st_data : '0;
                lsu_bus_byteenable       = req ? (lsu_mem_read ? 4'b1111 : st_be) : 4'b0000;
                lsu_stall                = req & lsu_bus_waitrequest;
                lsu_exc_load_misaligned  = lsu_mem_read & misaligned;
                lsu_exc_store_misaligned = lsu_mem_write & misaligned;
            end
            WAIT_DATA: begin
                lsu_stall    = ~lsu_bus_readdatavalid;
                lsu_readdata = (lsu_bus_readdatavalid & ~lsu_flush) ? ld_data : '0;
            end
            // A killed load is still in flight: hold any new request off the bus
            DRAIN: begin
                lsu_stall = lsu_mem_read | lsu_mem_write;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire
